ring_osc_autotrim: RTL and testbench

- Closed-loop trim controller for the 13-stage, 26-bit-trim ring oscillator; drives that oscillator's trim bus directly.
- Runs on the oscillator's own output clock and counts its cycles over windows set by a slow external reference (ref_in), then steps the trim level up or down until the count falls within target ± tol.
- Also supports a manual trim override.

---
 rtl/ring_osc_autotrim.sv | 149 ++++++++++++++
 tb/tb_ring_osc_autotrim.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_autotrim.sv
// rtl/ring_osc_autotrim.sv - closed-loop trim controller for the 13-stage, 26-bit-trim ring oscillator
module ring_osc_autotrim #(
    parameter int CNT_W      = 16,
    parameter int TRIM_INIT  = 13,
    parameter int LOCK_N     = 3,
    parameter int SETTLE_WIN = 1
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             enable,
    input  logic             ref_in,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] tol,
    input  logic             man_en,
    input  logic [4:0]       man_level,
    output logic [25:0]      trim,
    output logic [4:0]       level,
    output logic [CNT_W-1:0] count_last,
    output logic             locked,
    output logic             busy,
    output logic             sat
);

    typedef enum logic [2:0] {IDLE, ARM, MEAS, EVAL, SETTLE} state_t;

    localparam logic [CNT_W:0] CMAX = {1'b0, {CNT_W{1'b1}}};

    state_t           state;
    logic             ref_s1, ref_s2, ref_s3, ref_rise;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [7:0]       inb_cnt, settle_cnt;
    logic [CNT_W:0]   sum, hi, lo;
    logic             too_fast, too_slow;
    logic [4:0]       lvl_nxt;

    // Primary bits fill before secondary bits, so the whole bus is a 26-bit thermometer code.
    function automatic logic [25:0] lvl2trim(input logic [4:0] l);
        logic [25:0] t;
        for (int i = 0; i < 26; i++) t[i] = (5'(i) < l);
        return t;
    endfunction

    assign ref_rise = ref_s2 & ~ref_s3;
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
    assign sum      = {1'b0, target} + {1'b0, tol};
    assign hi       = (sum > CMAX) ? CMAX : sum;
    assign lo       = (tol > target) ? '0 : {1'b0, target - tol};
    assign too_fast = ({1'b0, count_last} > hi);
    assign too_slow = ({1'b0, count_last} < lo);

    always_comb begin
        lvl_nxt = level;
        if (man_en) begin
            lvl_nxt = (man_level > 5'd26) ? 5'd26 : man_level;
        end else if (enable && state == EVAL && !sat) begin
            if (too_fast && level < 5'd26)
                lvl_nxt = level + 5'd1;
            else if (too_slow && level > 5'd0)
                lvl_nxt = level - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            ref_s1     <= 1'b0;
            ref_s2     <= 1'b0;
            ref_s3     <= 1'b0;
            cnt        <= '0;
            inb_cnt    <= '0;
            settle_cnt <= '0;
            level      <= 5'(TRIM_INIT);
            trim       <= lvl2trim(5'(TRIM_INIT));
            count_last <= '0;
            locked     <= 1'b0;
            busy       <= 1'b0;
            sat        <= 1'b0;
        end else begin
            ref_s1 <= ref_in;
            ref_s2 <= ref_s1;
            ref_s3 <= ref_s2;
            level  <= lvl_nxt;
            trim   <= lvl2trim(lvl_nxt);

            if (man_en || !enable) begin
                state   <= IDLE;
                busy    <= 1'b0;
                locked  <= 1'b0;
                cnt     <= '0;
                inb_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b1;
                        cnt  <= '0;
                        state <= ref_rise ? MEAS : ARM;
                    end
                    ARM: begin
                        if (ref_rise) begin
                            cnt   <= '0;
                            state <= MEAS;
                        end
                    end
                    MEAS: begin
                        // The closing edge counts too, so a period of P clocks reads P.
                        if (ref_rise) begin
                            count_last <= cnt_inc;
                            cnt        <= '0;
                            state      <= EVAL;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    EVAL: begin
                        cnt <= cnt_inc;
                        if (too_fast || too_slow) begin
                            locked  <= 1'b0;
                            inb_cnt <= '0;
                            if (lvl_nxt == level) sat <= 1'b1;
                        end else begin
                            if (!(&inb_cnt)) inb_cnt <= inb_cnt + 8'd1;
                            if (int'(inb_cnt) + 1 >= LOCK_N) locked <= 1'b1;
                            sat <= 1'b0;
                        end
                        if (lvl_nxt != level) begin
                            settle_cnt <= 8'(SETTLE_WIN);
                            state      <= SETTLE;
                        end else begin
                            state <= MEAS;
                        end
                    end
                    SETTLE: begin
                        // The window open at entry is dropped, then SETTLE_WIN whole windows.
                        if (ref_rise) begin
                            if (settle_cnt == 8'd0) begin
                                cnt   <= '0;
                                state <= MEAS;
                            end else begin
                                settle_cnt <= settle_cnt - 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_osc_autotrim.sv
// tb/tb_ring_osc_autotrim.sv - directed table-driven bench for ring_osc_autotrim
module tb_ring_osc_autotrim;

    logic        clk = 1'b0;
    logic        resetb, enable, ref_in, man_en;
    logic [15:0] target, tol;
    logic [4:0]  man_level;
    logic [25:0] trim;
    logic [4:0]  level;
    logic [15:0] count_last;
    logic        locked, busy, sat;

    logic [7:0]  target2, tol2;
    logic [25:0] trim2;
    logic [4:0]  level2;
    logic [7:0]  count_last2;
    logic        locked2, busy2, sat2;

    int total = 0;
    int bad   = 0;

    int ref_period = 100;
    int ref_ph     = 0;
    logic ref_run  = 1'b0;

    always #5 clk = ~clk;

    ring_osc_autotrim dut (
        .clk(clk), .resetb(resetb), .enable(enable), .ref_in(ref_in),
        .target(target), .tol(tol), .man_en(man_en), .man_level(man_level),
        .trim(trim), .level(level), .count_last(count_last),
        .locked(locked), .busy(busy), .sat(sat)
    );

    ring_osc_autotrim #(.CNT_W(8)) dut8 (
        .clk(clk), .resetb(resetb), .enable(enable), .ref_in(ref_in),
        .target(target2), .tol(tol2), .man_en(man_en), .man_level(man_level),
        .trim(trim2), .level(level2), .count_last(count_last2),
        .locked(locked2), .busy(busy2), .sat(sat2)
    );

    // Reference generator: first rise one edge after ref_run goes high, period ref_period clocks.
    always @(posedge clk) begin
        #1;
        if (!ref_run) begin
            ref_ph = 0;
            ref_in = 1'b0;
        end else begin
            ref_in = (ref_ph < ref_period / 2);
            ref_ph = (ref_ph + 1 >= ref_period) ? 0 : ref_ph + 1;
        end
    end

    typedef struct {
        int          period;
        int          nwin;
        logic [15:0] target;
        logic [15:0] tol;
        logic        man_en;
        logic [4:0]  man_level;
        logic [4:0]  e_level;
        logic [25:0] e_trim;
        logic [15:0] e_cnt;
        logic        e_locked;
        logic        e_sat;
        logic        e_busy;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        ref_run = 1'b0;
        resetb  = 1'b0;
        enable  = 1'b0;
        man_en  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        string s;
        do_reset();
        target     = v.target;
        tol        = v.tol;
        man_en     = v.man_en;
        man_level  = v.man_level;
        ref_period = v.period;
        resetb     = 1'b1;
        enable     = 1'b1;
        ref_run    = 1'b1;
        wait_clks(v.nwin * v.period + 8);
        s = $sformatf("v%0d", idx);
        chk({s, ".level"},  32'(level),      32'(v.e_level));
        chk({s, ".trim"},   32'(trim),       32'(v.e_trim));
        chk({s, ".count"},  32'(count_last), 32'(v.e_cnt));
        chk({s, ".locked"}, 32'(locked),     32'(v.e_locked));
        chk({s, ".sat"},    32'(sat),        32'(v.e_sat));
        chk({s, ".busy"},   32'(busy),       32'(v.e_busy));
    endtask

    initial begin
        resetb = 1'b0; enable = 1'b0; man_en = 1'b0; man_level = 5'd0;
        target = 16'd100; tol = 16'd2; target2 = 8'd200; tol2 = 8'd100;

        vecs[0]  = '{110, 1, 16'd100, 16'd2,  1'b0, 5'd0,  5'd14, 26'h0003FFF, 16'd110, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{110, 3, 16'd100, 16'd2,  1'b0, 5'd0,  5'd14, 26'h0003FFF, 16'd110, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{110, 4, 16'd100, 16'd2,  1'b0, 5'd0,  5'd15, 26'h0007FFF, 16'd110, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{101, 2, 16'd100, 16'd2,  1'b0, 5'd0,  5'd13, 26'h0001FFF, 16'd101, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{101, 3, 16'd100, 16'd2,  1'b0, 5'd0,  5'd13, 26'h0001FFF, 16'd101, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{90,  1, 16'd100, 16'd2,  1'b0, 5'd0,  5'd12, 26'h0000FFF, 16'd90,  1'b0, 1'b0, 1'b1};
        vecs[6]  = '{102, 3, 16'd100, 16'd2,  1'b0, 5'd0,  5'd13, 26'h0001FFF, 16'd102, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{98,  3, 16'd100, 16'd2,  1'b0, 5'd0,  5'd13, 26'h0001FFF, 16'd98,  1'b1, 1'b0, 1'b1};
        vecs[8]  = '{103, 1, 16'd100, 16'd2,  1'b0, 5'd0,  5'd14, 26'h0003FFF, 16'd103, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{97,  1, 16'd100, 16'd2,  1'b0, 5'd0,  5'd12, 26'h0000FFF, 16'd97,  1'b0, 1'b0, 1'b1};
        vecs[10] = '{20,  3, 16'd50,  16'd60, 1'b0, 5'd0,  5'd13, 26'h0001FFF, 16'd20,  1'b1, 1'b0, 1'b1};
        vecs[11] = '{100, 0, 16'd100, 16'd2,  1'b1, 5'd31, 5'd26, 26'h3FFFFFF, 16'd0,   1'b0, 1'b0, 1'b0};
        vecs[12] = '{100, 0, 16'd100, 16'd2,  1'b1, 5'd0,  5'd0,  26'h0000000, 16'd0,   1'b0, 1'b0, 1'b0};
        vecs[13] = '{100, 0, 16'd100, 16'd2,  1'b1, 5'd5,  5'd5,  26'h000001F, 16'd0,   1'b0, 1'b0, 1'b0};
        vecs[14] = '{100, 0, 16'd100, 16'd2,  1'b1, 5'd20, 5'd20, 26'h00FFFFF, 16'd0,   1'b0, 1'b0, 1'b0};

        // Reset values.
        do_reset();
        chk("rst.trim",   32'(trim),       32'h0001FFF);
        chk("rst.level",  32'(level),      32'd13);
        chk("rst.locked", 32'(locked),     32'd0);
        chk("rst.busy",   32'(busy),       32'd0);
        chk("rst.count",  32'(count_last), 32'd0);
        chk("rst.sat",    32'(sat),        32'd0);

        for (int i = 0; i < 15; i++) apply_vec(i, vecs[i]);

        // Upper saturation: manual 31 -> 26, then a fast count cannot step past 26.
        do_reset();
        resetb = 1'b1; enable = 1'b1; man_en = 1'b1; man_level = 5'd31;
        target = 16'd100; tol = 16'd2;
        wait_clks(3);
        chk("sathi.man_level", 32'(level), 32'd26);
        chk("sathi.man_trim",  32'(trim),  32'h3FFFFFF);
        man_en = 1'b0; ref_period = 200; ref_run = 1'b1;
        wait_clks(208);
        chk("sathi.sat",   32'(sat),        32'd1);
        chk("sathi.level", 32'(level),      32'd26);
        chk("sathi.count", 32'(count_last), 32'd200);
        wait_clks(200);
        chk("sathi.sat2",   32'(sat),   32'd1);
        chk("sathi.level2", 32'(level), 32'd26);

        // Lower saturation at level 0 with a slow count.
        do_reset();
        resetb = 1'b1; enable = 1'b1; man_en = 1'b1; man_level = 5'd0;
        wait_clks(3);
        chk("satlo.man_trim", 32'(trim), 32'h0);
        man_en = 1'b0; ref_period = 50; ref_run = 1'b1;
        wait_clks(58);
        chk("satlo.sat",   32'(sat),        32'd1);
        chk("satlo.level", 32'(level),      32'd0);
        chk("satlo.count", 32'(count_last), 32'd50);

        // Lock, then a slow period drops lock and steps down on the next EVAL.
        do_reset();
        target = 16'd100; tol = 16'd2; ref_period = 101;
        resetb = 1'b1; enable = 1'b1; ref_run = 1'b1;
        wait_clks(311);
        chk("lock.locked", 32'(locked), 32'd1);
        ref_period = 90;
        wait_clks(94);
        chk("unlock.locked", 32'(locked),     32'd0);
        chk("unlock.level",  32'(level),      32'd12);
        chk("unlock.count",  32'(count_last), 32'd90);

        // 8-bit counter: 300-clock period saturates at 255 and hi saturates, so no step.
        do_reset();
        target2 = 8'd200; tol2 = 8'd100; ref_period = 300;
        resetb = 1'b1; enable = 1'b1; ref_run = 1'b1;
        wait_clks(308);
        chk("cnt8.count", 32'(count_last2), 32'd255);
        chk("cnt8.level", 32'(level2),      32'd13);

        // enable drop mid-MEAS, then re-enable waits for a fresh rising edge.
        do_reset();
        target = 16'd100; tol = 16'd2; ref_period = 101;
        resetb = 1'b1; enable = 1'b1; ref_run = 1'b1;
        wait_clks(109);
        enable = 1'b0;
        wait_clks(1);
        chk("drop.busy",   32'(busy),       32'd0);
        chk("drop.level",  32'(level),      32'd13);
        chk("drop.count",  32'(count_last), 32'd101);
        wait_clks(150);
        chk("drop.hold",   32'(count_last), 32'd101);
        ref_period = 110; enable = 1'b1;
        wait_clks(60);
        chk("reen.busy",   32'(busy),       32'd1);
        chk("reen.count0", 32'(count_last), 32'd101);
        wait_clks(120);
        chk("reen.count",  32'(count_last), 32'd110);
        chk("reen.level",  32'(level),      32'd14);

        // Asynchronous reset mid-operation, checked without a clock edge.
        resetb = 1'b0;
        #1;
        chk("arst.level", 32'(level),      32'd13);
        chk("arst.count", 32'(count_last), 32'd0);
        chk("arst.busy",  32'(busy),       32'd0);
        chk("arst.trim",  32'(trim),       32'h0001FFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
